uart_rx_frame_checker: RTL and testbench
========================================

# uart_rx_frame_checker

Serial frame checker for the UART receiver. It sits between the bit sampler and the receive FIFO. It takes one sampled bit per strobe, assembles the data word, and computes parity on the fly. It supports runtime-selectable data length, parity mode and stop-bit count. At the end of each frame it reports the data word together with parity, framing and break status.

## Interface
Parameters:
- DATA_WIDTH, 8: maximum data bits per frame; legal range 5..9.
- CNT_WIDTH, 8: width of each error counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- frame_start  input  1  pulse; the sampler has validated a start bit; opens a new frame.
- bit_valid  input  1  pulse; sampled_bit is valid this cycle.
- sampled_bit  input  1  mid-bit sample, LSB-first data order.
- data_len  input  4  data bits per frame; values <5 or >DATA_WIDTH are treated as DATA_WIDTH.
- parity_mode  input  3  0 none, 1 even, 2 odd, 3 mark, 4 space; values 5–7 are treated as none.
- two_stop  input  1  1 = two stop bits are expected.
- clear_counters  input  1  synchronous clear of the error counters.
- data_out  output  DATA_WIDTH  received word, zero-extended above data_len.
- frame_valid  output  1  one-cycle pulse; the frame is complete.
- parity_error  output  1  qualified by frame_valid.
- framing_error  output  1  qualified by frame_valid.
- break_detect  output  1  qualified by frame_valid.
- busy  output  1  high while a frame is open.
- parity_err_cnt, framing_err_cnt, break_cnt  output  CNT_WIDTH each  error counters (only when the counter feature is compiled in; see Configuration).

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2, DONE.
- IDLE:
  - On frame_start, latch data_len, parity_mode and two_stop; these stay fixed for the whole frame.
  - Clear the bit counter, shift register and running parity, then go to DATA.
- DATA:
  - Each bit_valid shifts sampled_bit into position bit_count and XORs it into the running parity acc.
  - After data_len bits, go to PARITY if the mode is not none, otherwise go to STOP1.
- PARITY: one bit_valid captures pbit, and the parity error is computed as:
  - even: acc^pbit
  - odd: ~(acc^pbit)
  - mark: ~pbit
  - space: pbit
- STOP1: one bit_valid. A 0 sets the framing error. Go to STOP2 if two_stop, else go to DONE.
- STOP2: one bit_valid. A 0 sets the framing error. Go to DONE.
- DONE: for one cycle, pulse frame_valid, present the outputs, then return to IDLE.
- Break detection: break_detect = 1 when all data bits, the parity bit (if present) and STOP1 are all 0. framing_error is also 1 in that case.
- parity_error is 0 whenever the mode is none.
- frame_start while busy aborts the current frame with no frame_valid, then restarts at DATA with freshly latched configuration.
- bit_valid in IDLE or DONE is ignored.
- frame_start and bit_valid in the same cycle: frame_start wins and the bit is discarded.
- data_out holds its value until the next frame_valid. Error flags are 0 except during the frame_valid cycle.

## Timing
- Reset values: data_out 0, frame_valid 0, parity_error 0, framing_error 0, break_detect 0, busy 0, all counters 0, FSM in IDLE.
- busy rises the cycle after frame_start and falls with the frame_valid pulse.
- frame_valid asserts exactly one clk after the bit_valid of the final stop bit.
- Reset asserted mid-frame clears everything immediately. No frame_valid is produced for the aborted frame.
- bit_valid may arrive every cycle; there is no minimum spacing between strobes.

## Configuration
- Macro: UART_RX_ERR_CNT_EN.
- Defined:
  - Three saturating counters (parity, framing, break) increment on frame_valid when the matching flag is set.
  - Each counter holds at all-ones once saturated.
  - clear_counters zeroes the counters. If clear_counters and an increment occur in the same cycle, the clear wins.
- Undefined: the counter ports and logic are absent, and clear_counters is ignored.

## Test plan
- 8 data bits, even parity, one stop bit, data 0xA5, pbit 0, stop 1 -> data_out 0xA5, all flags 0, frame_valid 1 clk after the stop bit.
- 7 data bits, odd parity, data 0x35 (four ones), pbit 0 -> parity_error 1. Repeat with pbit 1 -> parity_error 0.
- 8 data bits, no parity, two stop bits, second stop bit 0 -> framing_error 1, break_detect 0, data_out correct.
- All bits 0 including the stop bit, even parity -> break_detect 1, framing_error 1. With counters enabled, break_cnt and framing_err_cnt become 1.
- frame_start after 3 data bits, followed by a full frame of 0x3C -> exactly one frame_valid, data_out 0x3C.
- CNT_WIDTH 2, five parity-error frames -> parity_err_cnt saturates at 3. Then clear_counters -> 0.
- Reset asserted mid-frame -> all outputs return to their reset values immediately, no frame_valid.

Source files
------------

// File: rtl/uart_rx_frame_checker.sv
// UART receive frame checker: assembles LSB-first data bits, checks parity, stop bits and break.
// Optional saturating error counters are compiled in with `define UART_RX_ERR_CNT_EN.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  bit_valid,
  input  logic                  sampled_bit,
  input  logic [3:0]            data_len,
  input  logic [2:0]            parity_mode,
  input  logic                  two_stop,
  input  logic                  clear_counters,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  frame_valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  break_detect,
  output logic                  busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  parity_err_cnt,
  output logic [CNT_WIDTH-1:0]  framing_err_cnt,
  output logic [CNT_WIDTH-1:0]  break_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_DONE
  } state_e;

  typedef enum logic [2:0] {
    P_NONE, P_EVEN, P_ODD, P_MARK, P_SPACE
  } parity_e;

  state_e                 state_q;
  parity_e                mode_q, mode_d;
  logic [3:0]             len_q, len_d;
  logic                   two_stop_q;
  logic [3:0]             cnt_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   acc_q;
  logic                   any_one_q;
  logic                   perr_q, perr_d;
  logic                   stop1_zero_q;
  logic                   fin_ferr_d, fin_brk_d;

  logic [DATA_WIDTH-1:0]  data_out_q;
  logic                   frame_valid_q, parity_error_q, framing_error_q, break_detect_q, busy_q;

  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    len_d = data_len;
    if (data_len < 4'd5 || int'(data_len) > DATA_WIDTH) len_d = 4'(DATA_WIDTH);

    mode_d = P_NONE;
    case (parity_mode)
      3'd1:    mode_d = P_EVEN;
      3'd2:    mode_d = P_ODD;
      3'd3:    mode_d = P_MARK;
      3'd4:    mode_d = P_SPACE;
      default: mode_d = P_NONE;
    endcase

    perr_d = 1'b0;
    case (mode_q)
      P_EVEN:  perr_d = acc_q ^ sampled_bit;
      P_ODD:   perr_d = ~(acc_q ^ sampled_bit);
      P_MARK:  perr_d = ~sampled_bit;
      P_SPACE: perr_d = sampled_bit;
      default: perr_d = 1'b0;
    endcase

    // Status of a frame that closes on the current stop bit.
    fin_ferr_d = ~sampled_bit | ((state_q == S_STOP2) & stop1_zero_q);
    fin_brk_d  = ~any_one_q & ((state_q == S_STOP2) ? stop1_zero_q : ~sampled_bit);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      mode_q          <= P_NONE;
      len_q           <= '0;
      two_stop_q      <= 1'b0;
      cnt_q           <= '0;
      shift_q         <= '0;
      acc_q           <= 1'b0;
      any_one_q       <= 1'b0;
      perr_q          <= 1'b0;
      stop1_zero_q    <= 1'b0;
      data_out_q      <= '0;
      frame_valid_q   <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      break_detect_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      frame_valid_q   <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      break_detect_q  <= 1'b0;

      // A new start bit always wins: it aborts any open frame and drops a coincident bit.
      if (frame_start) begin
        state_q      <= S_DATA;
        len_q        <= len_d;
        mode_q       <= mode_d;
        two_stop_q   <= two_stop;
        cnt_q        <= '0;
        shift_q      <= '0;
        acc_q        <= 1'b0;
        any_one_q    <= 1'b0;
        perr_q       <= 1'b0;
        stop1_zero_q <= 1'b0;
        busy_q       <= 1'b1;
      end else begin
        case (state_q)
          S_DATA: if (bit_valid) begin
            shift_q   <= shift_q | (DATA_WIDTH'(sampled_bit) << cnt_q);
            acc_q     <= acc_q ^ sampled_bit;
            any_one_q <= any_one_q | sampled_bit;
            cnt_q     <= cnt_q + 4'd1;
            if (cnt_q == len_q - 4'd1) state_q <= (mode_q == P_NONE) ? S_STOP1 : S_PARITY;
          end
          S_PARITY: if (bit_valid) begin
            perr_q    <= perr_d;
            any_one_q <= any_one_q | sampled_bit;
            state_q   <= S_STOP1;
          end
          S_STOP1, S_STOP2: if (bit_valid) begin
            stop1_zero_q <= (state_q == S_STOP1) ? ~sampled_bit : stop1_zero_q;
            if (state_q == S_STOP1 && two_stop_q) begin
              state_q <= S_STOP2;
            end else begin
              state_q         <= S_DONE;
              frame_valid_q   <= 1'b1;
              parity_error_q  <= perr_q;
              framing_error_q <= fin_ferr_d;
              break_detect_q  <= fin_brk_d;
              data_out_q      <= shift_q;
              busy_q          <= 1'b0;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign data_out      = data_out_q;
  assign frame_valid   = frame_valid_q;
  assign parity_error  = parity_error_q;
  assign framing_error = framing_error_q;
  assign break_detect  = break_detect_q;
  assign busy          = busy_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt_q, frm_cnt_q, brk_cnt_q;

  // Counters saturate at all-ones; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      brk_cnt_q <= '0;
    end else if (clear_counters) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      brk_cnt_q <= '0;
    end else if (frame_valid_q) begin
      if (parity_error_q  && par_cnt_q != '1) par_cnt_q <= par_cnt_q + CNT_WIDTH'(1);
      if (framing_error_q && frm_cnt_q != '1) frm_cnt_q <= frm_cnt_q + CNT_WIDTH'(1);
      if (break_detect_q  && brk_cnt_q != '1) brk_cnt_q <= brk_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign parity_err_cnt  = par_cnt_q;
  assign framing_err_cnt = frm_cnt_q;
  assign break_cnt       = brk_cnt_q;
`else
  logic unused_clear_counters;
  assign unused_clear_counters = clear_counters;
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Randomized self-checking bench for uart_rx_frame_checker against a frame-level reference model.
// Counter checks are included when UART_RX_ERR_CNT_EN is defined.
module tb_uart_rx_frame_checker;
  localparam int DW   = 8;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          frame_start = 1'b0, bit_valid = 1'b0, sampled_bit = 1'b0;
  logic [3:0]    data_len = '0;
  logic [2:0]    parity_mode = '0;
  logic          two_stop = 1'b0, clear_counters = 1'b0;
  logic [DW-1:0] data_out;
  logic          frame_valid, parity_error, framing_error, break_detect, busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [CW-1:0] parity_err_cnt, framing_err_cnt, break_cnt;
`endif

  uart_rx_frame_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bit_valid(bit_valid),
    .sampled_bit(sampled_bit), .data_len(data_len), .parity_mode(parity_mode),
    .two_stop(two_stop), .clear_counters(clear_counters), .data_out(data_out),
    .frame_valid(frame_valid), .parity_error(parity_error), .framing_error(framing_error),
    .break_detect(break_detect), .busy(busy)
`ifdef UART_RX_ERR_CNT_EN
    , .parity_err_cnt(parity_err_cnt), .framing_err_cnt(framing_err_cnt), .break_cnt(break_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    logic [3:0] len;
    logic [2:0] mode;
    logic       two;
    logic       pbit;
    logic       s1;
    logic       s2;
  } frame_t;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] last_data = '0;
  int            exp_pc = 0, exp_fc = 0, exp_bc = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // status vector: {frame_valid, parity_error, framing_error, break_detect, busy}
  function automatic logic [4:0] status();
    return {frame_valid, parity_error, framing_error, break_detect, busy};
  endfunction

  task automatic check_idle_status(input string name, input logic [4:0] exp);
    tests++;
    if (status() !== exp) begin
      fails++;
      $display("FAIL %s status got %b exp %b", name, status(), exp);
    end
    tests++;
    if (data_out !== last_data) begin
      fails++;
      $display("FAIL %s data_out got %h exp %h", name, data_out, last_data);
    end
`ifdef UART_RX_ERR_CNT_EN
    tests++;
    if ({parity_err_cnt, framing_err_cnt, break_cnt} !== {CW'(exp_pc), CW'(exp_fc), CW'(exp_bc)}) begin
      fails++;
      $display("FAIL %s counters got %0d/%0d/%0d exp %0d/%0d/%0d", name,
               parity_err_cnt, framing_err_cnt, break_cnt, exp_pc, exp_fc, exp_bc);
    end
`endif
  endtask

  // Drives one frame bit by bit and checks it against the frame-level model.
  task automatic send_frame(input string name, input frame_t f, input int max_gap,
                            input bit chain, input bit with_bit, input bit clr_on_valid);
    int            len, ones;
    bit            has_par;
    logic [DW-1:0] d;
    logic          pe, fe, be;
    bit            bits[$];

    len     = (f.len < 5 || f.len > DW) ? DW : int'(f.len);
    d       = f.data[DW-1:0] & DW'((1 << len) - 1);
    has_par = f.mode inside {[3'd1:3'd4]};
    ones    = $countones(d);
    case (f.mode)
      3'd1:    pe = ((ones + f.pbit) % 2) == 1;
      3'd2:    pe = ((ones + f.pbit) % 2) == 0;
      3'd3:    pe = !f.pbit;
      3'd4:    pe = f.pbit;
      default: pe = 1'b0;
    endcase
    fe = !f.s1 || (f.two && !f.s2);
    be = (d == '0) && (!has_par || !f.pbit) && !f.s1;
    for (int i = 0; i < len; i++) bits.push_back(d[i]);
    if (has_par) bits.push_back(f.pbit);
    bits.push_back(f.s1);
    if (f.two) bits.push_back(f.s2);

    frame_start = 1'b1;
    data_len = f.len; parity_mode = f.mode; two_stop = f.two;
    bit_valid = with_bit; sampled_bit = 1'b1;
    tick();
    frame_start = 1'b0; bit_valid = 1'b0;
    data_len = 4'($urandom); parity_mode = 3'($urandom); two_stop = 1'($urandom);
    check_idle_status({name, "/start"}, 5'b00001);

    for (int i = 0; i < bits.size(); i++) begin
      bit_valid = 1'b1; sampled_bit = bits[i];
      tick();
      bit_valid = 1'b0; sampled_bit = 1'($urandom);
      if (i < bits.size() - 1) begin
        tests++;
        if (status() !== 5'b00001) begin
          fails++;
          $display("FAIL %s/bit%0d status got %b exp 00001", name, i, status());
        end
        repeat ($urandom_range(0, max_gap)) begin
          tick();
          tests++;
          if (frame_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL %s/gap fv,busy got %b%b exp 01", name, frame_valid, busy);
          end
        end
      end
    end

    tests++;
    if (status() !== {1'b1, pe, fe, be, 1'b0}) begin
      fails++;
      $display("FAIL %s/valid status got %b exp %b", name, status(), {1'b1, pe, fe, be, 1'b0});
    end
    tests++;
    if (data_out !== d) begin
      fails++;
      $display("FAIL %s/valid data_out got %h exp %h", name, data_out, d);
    end
    last_data = d;
    if (clr_on_valid) begin
      clear_counters = 1'b1;
      exp_pc = 0; exp_fc = 0; exp_bc = 0;
    end else begin
      if (pe && exp_pc < CMAX) exp_pc++;
      if (fe && exp_fc < CMAX) exp_fc++;
      if (be && exp_bc < CMAX) exp_bc++;
    end
    if (!chain) begin
      tick();
      clear_counters = 1'b0;
      check_idle_status({name, "/after"}, 5'b00000);
    end
  endtask

  function automatic frame_t mk(input logic [8:0] data, input logic [3:0] len, input logic [2:0] mode,
                                input logic two, input logic pbit, input logic s1, input logic s2);
    frame_t f;
    f.data = data; f.len = len; f.mode = mode; f.two = two; f.pbit = pbit; f.s1 = s1; f.s2 = s2;
    return f;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    check_idle_status("reset_held", 5'b00000);
    reset = 1'b1;
    tick();
    check_idle_status("reset_released", 5'b00000);
  endtask

  task automatic test_directed();
    send_frame("even_a5",      mk(9'h0A5, 4'd8, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("odd_35_p0",    mk(9'h035, 4'd7, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("odd_35_p1",    mk(9'h035, 4'd7, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("two_stop_err", mk(9'h05A, 4'd8, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0), 1, 0, 0, 0);
    send_frame("break_even",   mk(9'h000, 4'd8, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0);
    send_frame("mark_p0",      mk(9'h013, 4'd5, 3'd3, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("space_p1",     mk(9'h0F3, 4'd15, 3'd4, 1'b0, 1'b1, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("mode7_none",   mk(9'h081, 4'd2, 3'd7, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
  endtask

  task automatic test_abort();
    frame_start = 1'b1; data_len = 4'd8; parity_mode = 3'd0; two_stop = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'b1;
      tick();
      bit_valid = 1'b0;
      check_idle_status("abort_partial", 5'b00001);
    end
    send_frame("abort_3c", mk(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
  endtask

  task automatic test_idle_and_same_cycle();
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'b1;
      tick();
      bit_valid = 1'b0;
      check_idle_status("idle_bits", 5'b00000);
    end
    send_frame("start_with_bit", mk(9'h080, 4'd8, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back();
    send_frame("b2b_0", mk(9'h1C7, 4'd9, 3'd1, 1'b1, 1'b1, 1'b1, 1'b1), 0, 1, 0, 0);
    send_frame("b2b_1", mk(9'h066, 4'd6, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1), 0, 1, 0, 0);
    send_frame("b2b_2", mk(9'h0FF, 4'd8, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0);
  endtask

  task automatic test_random();
    frame_t f;
    for (int n = 0; n < 60; n++) begin
      f = mk(9'($urandom), 4'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 5) == 0) begin
        f.data = '0; f.pbit = 1'b0; f.s1 = 1'b0;
      end
      send_frame("random", f, 2, (n < 59) ? 1'($urandom) : 1'b0, 1'($urandom_range(0, 7) == 0), 1'b0);
    end
  endtask

  task automatic test_counters();
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    exp_pc = 0; exp_fc = 0; exp_bc = 0;
    check_idle_status("cnt_clear0", 5'b00000);
    for (int i = 0; i < 5; i++)
      send_frame("cnt_par_sat", mk(9'h001, 4'd8, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
    send_frame("cnt_break", mk(9'h000, 4'd8, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0);
    clear_counters = 1'b1;
    tick();
    clear_counters = 1'b0;
    exp_pc = 0; exp_fc = 0; exp_bc = 0;
    check_idle_status("cnt_clear1", 5'b00000);
    send_frame("cnt_break2", mk(9'h000, 4'd8, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0);
    send_frame("cnt_clear_wins", mk(9'h003, 4'd8, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1), 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_frame();
    send_frame("pre_reset", mk(9'h0C3, 4'd8, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1), 0, 0, 0, 0);
    frame_start = 1'b1; data_len = 4'd8; parity_mode = 3'd1; two_stop = 1'b0;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'b1;
      tick();
    end
    bit_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    last_data = '0; exp_pc = 0; exp_fc = 0; exp_bc = 0;
    check_idle_status("reset_mid_frame", 5'b00000);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bit_valid = 1'b1; sampled_bit = 1'($urandom);
      tick();
      check_idle_status("post_reset_bits", 5'b00000);
    end
    bit_valid = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_abort();
    test_idle_and_same_cycle();
    test_back_to_back();
    test_random();
`ifdef UART_RX_ERR_CNT_EN
    test_counters();
`endif
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
